// File: rtl/tx_iq_mc_intf.sv
// -----------------------------------------------------------------------------
// tx_iq_mc_intf
//
// Multi-channel TX IQ interface. Per-channel I/Q samples are scaled by a
// signed per-channel gain, buffered in a first-word-fall-through FIFO and
// presented to the downstream consumer. Alternatively the consumer is fed
// straight from an upstream s_axis-style source. A loopback tap selects
// either the s_axis data or the raw RF input.
//
// Optional build macro:
//   TX_IQ_GAIN_SAT_EN  - when defined, each scaled sample saturates to the
//                        signed IQ_DATA_WIDTH range; otherwise it wraps
//                        (plain bit-slice of the shifted product).
//
// Packing: channel n occupies {q,i} at bit offset n*2*IQ_DATA_WIDTH,
//          channel 0 at the LSB, I in the lower half.
//
// Ports:
//   clk                  single clock
//   rst                  asynchronous active-high reset
//   rf_iq / rf_iq_valid  signed packed RF samples and their strobe
//   bb_gain              signed gain per channel (NUM_CH x GAIN_WIDTH)
//   src_sel              0 = gain path through FIFO, 1 = s_axis passthrough
//   loopback_sel         0 = loop back s_axis data, 1 = loop back rf_iq
//   cnt_clr              synchronous clear of underrun/overflow counters
//   data_from_s_axis     upstream packed data
//   emptyn_from_s_axis   upstream data available
//   ask_data_from_s_axis upstream read request
//   wifi_iq_pack/_valid  downstream data and valid
//   wifi_iq_ready        downstream ready (pops the FIFO)
//   data_loopback/_valid loopback tap
//   tx_iq_fifo_empty/_full, fifo_level  FIFO status
//   underrun_cnt         cycles the consumer wanted data from an empty FIFO
//   overflow_cnt         gain-path words dropped on a full FIFO
// -----------------------------------------------------------------------------
module tx_iq_mc_intf #(
  parameter  int NUM_CH        = 2,
  parameter  int IQ_DATA_WIDTH = 16,
  parameter  int GAIN_WIDTH    = 10,
  parameter  int GAIN_SHIFT    = 7,
  parameter  int FIFO_AW       = 5,
  localparam int PACK_W        = NUM_CH * 2 * IQ_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [PACK_W-1:0]            rf_iq,
  input  logic                         rf_iq_valid,
  input  logic [NUM_CH*GAIN_WIDTH-1:0] bb_gain,

  input  logic                         src_sel,
  input  logic                         loopback_sel,
  input  logic                         cnt_clr,

  input  logic [PACK_W-1:0]            data_from_s_axis,
  input  logic                         emptyn_from_s_axis,
  output logic                         ask_data_from_s_axis,

  output logic [PACK_W-1:0]            wifi_iq_pack,
  output logic                         wifi_iq_valid,
  input  logic                         wifi_iq_ready,

  output logic [PACK_W-1:0]            data_loopback,
  output logic                         data_loopback_valid,

  output logic                         tx_iq_fifo_empty,
  output logic                         tx_iq_fifo_full,
  output logic [FIFO_AW:0]             fifo_level,
  output logic [15:0]                  underrun_cnt,
  output logic [15:0]                  overflow_cnt
);

  localparam int PROD_W = GAIN_WIDTH + IQ_DATA_WIDTH;
  localparam int DEPTH  = 1 << FIFO_AW;

  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [15:0]        CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Sample scaling: shift the full product right by GAIN_SHIFT, then either
  // clamp to the signed sample range or keep the low IQ_DATA_WIDTH bits.
  // ---------------------------------------------------------------------------
`ifdef TX_IQ_GAIN_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(GAIN_WIDTH+1){1'b0}}, {(IQ_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(GAIN_WIDTH+1){1'b1}}, {(IQ_DATA_WIDTH-1){1'b0}}};

  function automatic logic [IQ_DATA_WIDTH-1:0] scale_sample(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> GAIN_SHIFT;
    if (shifted > SAT_MAX)
      scale_sample = SAT_MAX[IQ_DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)
      scale_sample = SAT_MIN[IQ_DATA_WIDTH-1:0];
    else
      scale_sample = shifted[IQ_DATA_WIDTH-1:0];
  endfunction
`else
  // Truncating the shifted product is the same as slicing
  // prod[GAIN_SHIFT+IQ_DATA_WIDTH-1:GAIN_SHIFT]; out-of-range values wrap.
  function automatic logic [IQ_DATA_WIDTH-1:0] scale_sample(
    input logic signed [PROD_W-1:0] prod
  );
    scale_sample = IQ_DATA_WIDTH'(prod >>> GAIN_SHIFT);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: registered per-channel products and FIFO write request.
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_i [NUM_CH];
  logic signed [PROD_W-1:0] prod_q [NUM_CH];
  logic                     wr_en;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        prod_i[n] <= '0;
        prod_q[n] <= '0;
      end
      wr_en <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        // Sign-extend both operands to the product width before multiplying.
        prod_i[n] <= PROD_W'($signed(rf_iq[n*2*IQ_DATA_WIDTH +: IQ_DATA_WIDTH]))
                   * PROD_W'($signed(bb_gain[n*GAIN_WIDTH +: GAIN_WIDTH]));
        prod_q[n] <= PROD_W'($signed(rf_iq[n*2*IQ_DATA_WIDTH+IQ_DATA_WIDTH +: IQ_DATA_WIDTH]))
                   * PROD_W'($signed(bb_gain[n*GAIN_WIDTH +: GAIN_WIDTH]));
      end
      wr_en <= rf_iq_valid & ~src_sel;
    end
  end

  logic [PACK_W-1:0] fifo_din;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fifo_din = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      fifo_din[n*2*IQ_DATA_WIDTH                 +: IQ_DATA_WIDTH] = scale_sample(prod_i[n]);
      fifo_din[n*2*IQ_DATA_WIDTH + IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = scale_sample(prod_q[n]);
    end
  end

  // ---------------------------------------------------------------------------
  // Source-switch detector: a one-cycle flush on every src_sel edge empties
  // the FIFO so stale gain-path words never follow a passthrough period.
  // ---------------------------------------------------------------------------
  logic s0, s1, flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= src_sel;
      s1 <= s0;
    end
  end

  assign flush = s0 ^ s1;

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [PACK_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               fifo_empty, fifo_full;
  logic               rden, wr_accept, wr_drop, underrun_evt;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);

  // A read is only honoured when a word is present, so a write into an empty
  // FIFO in the same cycle is stored and not immediately consumed.
  assign rden = ~src_sel & wifi_iq_ready & ~fifo_empty;

  // A full FIFO still accepts a write when the same cycle frees a slot.
  // Writes landing in a flush cycle are discarded without being counted.
  assign wr_accept    = wr_en & ~flush & (~fifo_full | rden);
  assign wr_drop      = wr_en & ~flush &  fifo_full & ~rden;
  assign underrun_evt = ~src_sel & wifi_iq_ready & fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rden)      rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_accept, rden})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through the level-qualified head word, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= fifo_din;
  end

  // ---------------------------------------------------------------------------
  // Saturating event counters (clear wins over increment)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else if (cnt_clr) begin
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      if (underrun_evt && underrun_cnt != CNT_MAX) underrun_cnt <= underrun_cnt + 16'd1;
      if (wr_drop      && overflow_cnt != CNT_MAX) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    wifi_iq_pack         = '0;
    wifi_iq_valid        = 1'b0;
    ask_data_from_s_axis = 1'b0;
    if (src_sel) begin
      wifi_iq_pack         = data_from_s_axis;
      wifi_iq_valid        = emptyn_from_s_axis;
      ask_data_from_s_axis = wifi_iq_ready;
    end else begin
      // The gain path always claims valid; an empty FIFO presents zeros.
      wifi_iq_valid = 1'b1;
      if (!fifo_empty) wifi_iq_pack = mem[rd_ptr];
    end
  end

  assign data_loopback       = loopback_sel ? rf_iq       : data_from_s_axis;
  assign data_loopback_valid = loopback_sel ? rf_iq_valid : emptyn_from_s_axis;

  assign tx_iq_fifo_empty = fifo_empty;
  assign tx_iq_fifo_full  = fifo_full;
  assign fifo_level       = level;

endmodule

// File: tb/tb_tx_iq_mc_intf.sv
// -----------------------------------------------------------------------------
// tb_tx_iq_mc_intf
//
// Self-checking bench for tx_iq_mc_intf (NUM_CH=2, 16-bit IQ, 10-bit gain,
// shift 7, 32-deep FIFO). Directed scenarios use hand-computed constants; a
// randomized run compares every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_tx_iq_mc_intf;

  localparam int NUM_CH = 2;
  localparam int W      = 16;
  localparam int GW     = 10;
  localparam int GS     = 7;
  localparam int AW     = 5;
  localparam int PACK_W = NUM_CH * 2 * W;
  localparam int DEPTH  = 1 << AW;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PACK_W-1:0]        rf_iq;
  logic                     rf_iq_valid;
  logic [NUM_CH*GW-1:0]     bb_gain;
  logic                     src_sel;
  logic                     loopback_sel;
  logic                     cnt_clr;
  logic [PACK_W-1:0]        data_from_s_axis;
  logic                     emptyn_from_s_axis;
  logic                     ask_data_from_s_axis;
  logic [PACK_W-1:0]        wifi_iq_pack;
  logic                     wifi_iq_valid;
  logic                     wifi_iq_ready;
  logic [PACK_W-1:0]        data_loopback;
  logic                     data_loopback_valid;
  logic                     tx_iq_fifo_empty;
  logic                     tx_iq_fifo_full;
  logic [AW:0]              fifo_level;
  logic [15:0]              underrun_cnt;
  logic [15:0]              overflow_cnt;

  tx_iq_mc_intf #(
    .NUM_CH(NUM_CH), .IQ_DATA_WIDTH(W), .GAIN_WIDTH(GW),
    .GAIN_SHIFT(GS), .FIFO_AW(AW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rf_iq               (rf_iq),
    .rf_iq_valid         (rf_iq_valid),
    .bb_gain             (bb_gain),
    .src_sel             (src_sel),
    .loopback_sel        (loopback_sel),
    .cnt_clr             (cnt_clr),
    .data_from_s_axis    (data_from_s_axis),
    .emptyn_from_s_axis  (emptyn_from_s_axis),
    .ask_data_from_s_axis(ask_data_from_s_axis),
    .wifi_iq_pack        (wifi_iq_pack),
    .wifi_iq_valid       (wifi_iq_valid),
    .wifi_iq_ready       (wifi_iq_ready),
    .data_loopback       (data_loopback),
    .data_loopback_valid (data_loopback_valid),
    .tx_iq_fifo_empty    (tx_iq_fifo_empty),
    .tx_iq_fifo_full     (tx_iq_fifo_full),
    .fifo_level          (fifo_level),
    .underrun_cnt        (underrun_cnt),
    .overflow_cnt        (overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of stored words, one pending write (the gain
  // path takes one cycle), the two-stage src_sel history and two counters.
  // ---------------------------------------------------------------------------
  logic [PACK_W-1:0] mq [$];
  bit                m_pend;
  logic [PACK_W-1:0] m_pend_word;
  bit                m_s0, m_s1;
  int                m_und, m_ovf;

  function automatic logic [PACK_W-1:0] gain_word(input logic [PACK_W-1:0] iq,
                                                   input logic [NUM_CH*GW-1:0] g);
    logic [PACK_W-1:0] w;
    longint gv, x, s;
    logic [W-1:0] r;
    w = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      gv = longint'($signed(g[n*GW +: GW]));
      for (int k = 0; k < 2; k++) begin
        x = longint'($signed(iq[n*2*W + k*W +: W]));
        s = (x * gv) >>> GS;
`ifdef TX_IQ_GAIN_SAT_EN
        if (s > longint'((1 << (W-1)) - 1)) s = longint'((1 << (W-1)) - 1);
        if (s < -longint'(1 << (W-1)))      s = -longint'(1 << (W-1));
`endif
        r = s[W-1:0];
        w[n*2*W + k*W +: W] = r;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_pend_word = '0;
    m_s0 = 1'b0;
    m_s1 = 1'b0;
    m_und = 0;
    m_ovf = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit was_empty, pop, und_inc, ovf_inc;
    if (rst) begin
      model_reset();
      return;
    end
    was_empty = (mq.size() == 0);
    pop       = !src_sel && wifi_iq_ready && !was_empty;
    und_inc   = !src_sel && wifi_iq_ready && was_empty;
    ovf_inc   = 1'b0;
    if (m_s0 != m_s1) begin
      mq.delete();
    end else begin
      if (pop) mq.delete(0);
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_word);
        else ovf_inc = 1'b1;
      end
    end
    if (cnt_clr) begin
      m_und = 0;
      m_ovf = 0;
    end else begin
      if (und_inc && m_und < 65535) m_und++;
      if (ovf_inc && m_ovf < 65535) m_ovf++;
    end
    m_pend      = rf_iq_valid && !src_sel;
    m_pend_word = gain_word(rf_iq, bb_gain);
    m_s1        = m_s0;
    m_s0        = src_sel;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_rf();
    rf_iq   = {$urandom(), $urandom()};
    bb_gain = (NUM_CH*GW)'($urandom());
  endtask

  // Two src_sel edges: each produces a flush, leaving the FIFO empty.
  task automatic flush_fifo();
    src_sel = 1'b1;
    repeat (3) tick();
    src_sel = 1'b0;
    repeat (3) tick();
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, underrun_cnt, overflow_cnt}
        !== {1'b1, 1'b0, 6'd0, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_status got=%h exp=%h",
               {tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, underrun_cnt, overflow_cnt},
               {1'b1, 1'b0, 6'd0, 16'd0, 16'd0});
    end
    checks++;
    if ({wifi_iq_pack, wifi_iq_valid} !== {64'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_pack got=%h exp=%h", {wifi_iq_pack, wifi_iq_valid}, {64'd0, 1'b1});
    end
    rst = 1'b0;
    wifi_iq_ready = 1'b1;
    #1;
    checks++;
    if ({tx_iq_fifo_empty, fifo_level, underrun_cnt, wifi_iq_pack} !== {1'b1, 6'd0, 16'd0, 64'd0}) begin
      errors++;
      $display("FAIL after_reset got=%h exp=%h",
               {tx_iq_fifo_empty, fifo_level, underrun_cnt, wifi_iq_pack},
               {1'b1, 6'd0, 16'd0, 64'd0});
    end
    tick();
    checks++;
    if (underrun_cnt !== 16'd1) begin
      errors++;
      $display("FAIL first_underrun got=%0d exp=1", underrun_cnt);
    end
  endtask

  task automatic test_gain_basic();
    wifi_iq_ready = 1'b1;
    flush_fifo();
    // {q1, i1, q0, i0} = {-7, 300, -500, 1000}; gains ch1=64, ch0=128
    rf_iq       = {16'hFFF9, 16'd300, 16'hFE0C, 16'd1000};
    bb_gain     = {10'd64, 10'd128};
    rf_iq_valid = 1'b1;
    tick();
    rf_iq_valid = 1'b0;
    checks++;
    if ({wifi_iq_pack, fifo_level} !== {64'd0, 6'd0}) begin
      errors++;
      $display("FAIL gain_one_cycle got=%h exp=%h", {wifi_iq_pack, fifo_level}, {64'd0, 6'd0});
    end
    tick();
    checks++;
    if ({wifi_iq_pack, wifi_iq_valid, fifo_level}
        !== {16'hFFFC, 16'd150, 16'hFE0C, 16'd1000, 1'b1, 6'd1}) begin
      errors++;
      $display("FAIL gain_two_cycles got=%h exp=%h", {wifi_iq_pack, wifi_iq_valid, fifo_level},
               {16'hFFFC, 16'd150, 16'hFE0C, 16'd1000, 1'b1, 6'd1});
    end
    tick();
    checks++;
    if ({wifi_iq_pack, fifo_level, tx_iq_fifo_empty} !== {64'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL gain_popped got=%h exp=%h", {wifi_iq_pack, fifo_level, tx_iq_fifo_empty},
               {64'd0, 6'd0, 1'b1});
    end
  endtask

  task automatic test_gain_sat();
    logic [31:0] exp_w;
`ifdef TX_IQ_GAIN_SAT_EN
    exp_w = {16'h8000, 16'h7FFF};
`else
    exp_w = {16'h63C0, 16'h9C40};
`endif
    wifi_iq_ready = 1'b0;
    // ch0: i = 20000, q = -20000, gain 256 -> +/-40000 after the shift
    rf_iq       = {32'd0, 16'hB1E0, 16'h4E20};
    bb_gain     = {10'd0, 10'd256};
    rf_iq_valid = 1'b1;
    tick();
    rf_iq_valid = 1'b0;
    tick();
    checks++;
    if (wifi_iq_pack !== {32'd0, exp_w}) begin
      errors++;
      $display("FAIL gain_limit got=%h exp=%h", wifi_iq_pack, {32'd0, exp_w});
    end
    wifi_iq_ready = 1'b1;
    tick();
    wifi_iq_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [PACK_W-1:0] first_word;
    wifi_iq_ready = 1'b0;
    flush_fifo();
    clear_counters();
    rf_iq_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      randomize_rf();
      if (k == 0) first_word = gain_word(rf_iq, bb_gain);
      tick();
    end
    rf_iq_valid = 1'b0;
    tick();
    checks++;
    if ({fifo_level, tx_iq_fifo_full, tx_iq_fifo_empty, overflow_cnt}
        !== {6'd32, 1'b1, 1'b0, 16'd8}) begin
      errors++;
      $display("FAIL overflow_fill got=%h exp=%h",
               {fifo_level, tx_iq_fifo_full, tx_iq_fifo_empty, overflow_cnt},
               {6'd32, 1'b1, 1'b0, 16'd8});
    end
    checks++;
    if (wifi_iq_pack !== first_word) begin
      errors++;
      $display("FAIL overflow_head got=%h exp=%h", wifi_iq_pack, first_word);
    end
    // Arrange for the registered write to land in the same cycle as a pop.
    randomize_rf();
    rf_iq_valid = 1'b1;
    tick();
    rf_iq_valid   = 1'b0;
    wifi_iq_ready = 1'b1;
    tick();
    wifi_iq_ready = 1'b0;
    checks++;
    if ({fifo_level, tx_iq_fifo_full, overflow_cnt} !== {6'd32, 1'b1, 16'd8}) begin
      errors++;
      $display("FAIL overflow_rw got=%h exp=%h", {fifo_level, tx_iq_fifo_full, overflow_cnt},
               {6'd32, 1'b1, 16'd8});
    end
  endtask

  task automatic test_underrun();
    wifi_iq_ready = 1'b0;
    flush_fifo();
    clear_counters();
    wifi_iq_ready = 1'b1;
    repeat (10) tick();
    wifi_iq_ready = 1'b0;
    #1;
    checks++;
    if ({underrun_cnt, wifi_iq_pack, wifi_iq_valid} !== {16'd10, 64'd0, 1'b1}) begin
      errors++;
      $display("FAIL underrun_count got=%h exp=%h", {underrun_cnt, wifi_iq_pack, wifi_iq_valid},
               {16'd10, 64'd0, 1'b1});
    end
    wifi_iq_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    wifi_iq_ready = 1'b0;
    #1;
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL underrun_clear got=%0d exp=0", underrun_cnt);
    end
  endtask

  task automatic test_flush_passthrough();
    int waited;
    wifi_iq_ready = 1'b0;
    flush_fifo();
    rf_iq_valid = 1'b1;
    repeat (12) begin
      randomize_rf();
      tick();
    end
    rf_iq_valid = 1'b0;
    tick();
    checks++;
    if (fifo_level !== 6'd12) begin
      errors++;
      $display("FAIL flush_prefill got=%0d exp=12", fifo_level);
    end
    src_sel            = 1'b1;
    wifi_iq_ready      = 1'b1;
    emptyn_from_s_axis = 1'b1;
    data_from_s_axis   = {$urandom(), $urandom()};
    waited = 0;
    while (fifo_level !== 6'd0 && waited < 3) begin
      tick();
      waited++;
    end
    checks++;
    if ({fifo_level, tx_iq_fifo_empty} !== {6'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush_level got=%0d after %0d cycles exp=0", fifo_level, waited);
    end
    checks++;
    if ({wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis} !== {data_from_s_axis, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pass_ready got=%h exp=%h", {wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis},
               {data_from_s_axis, 1'b1, 1'b1});
    end
    wifi_iq_ready      = 1'b0;
    emptyn_from_s_axis = 1'b0;
    data_from_s_axis   = {$urandom(), $urandom()};
    #1;
    checks++;
    if ({wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis} !== {data_from_s_axis, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pass_idle got=%h exp=%h", {wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis},
               {data_from_s_axis, 1'b0, 1'b0});
    end
    randomize_rf();
    rf_iq_valid  = 1'b1;
    loopback_sel = 1'b1;
    #1;
    checks++;
    if ({data_loopback, data_loopback_valid} !== {rf_iq, 1'b1}) begin
      errors++;
      $display("FAIL loopback_rf got=%h exp=%h", {data_loopback, data_loopback_valid}, {rf_iq, 1'b1});
    end
    loopback_sel = 1'b0;
    #1;
    checks++;
    if ({data_loopback, data_loopback_valid} !== {data_from_s_axis, 1'b0}) begin
      errors++;
      $display("FAIL loopback_axis got=%h exp=%h", {data_loopback, data_loopback_valid},
               {data_from_s_axis, 1'b0});
    end
    rf_iq_valid = 1'b0;
    src_sel     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_burst();
    wifi_iq_ready = 1'b0;
    flush_fifo();
    clear_counters();
    rf_iq_valid = 1'b1;
    repeat (36) begin
      randomize_rf();
      tick();
    end
    // 35 writes have landed: 32 stored, 3 dropped.
    checks++;
    if ({fifo_level, overflow_cnt} !== {6'd32, 16'd3}) begin
      errors++;
      $display("FAIL burst_prefill got=%h exp=%h", {fifo_level, overflow_cnt}, {6'd32, 16'd3});
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, overflow_cnt, underrun_cnt, wifi_iq_pack}
        !== {1'b1, 1'b0, 6'd0, 16'd0, 16'd0, 64'd0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h",
               {tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, overflow_cnt, underrun_cnt, wifi_iq_pack},
               {1'b1, 1'b0, 6'd0, 16'd0, 16'd0, 64'd0});
    end
    tick();
    rf_iq_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_iq_fifo_empty, fifo_level, wifi_iq_pack} !== {1'b1, 6'd0, 64'd0}) begin
      errors++;
      $display("FAIL post_burst_reset got=%h exp=%h", {tx_iq_fifo_empty, fifo_level, wifi_iq_pack},
               {1'b1, 6'd0, 64'd0});
    end
  endtask

  task automatic test_random();
    int ready_pct;
    logic [PACK_W-1:0] exp_pack;
    logic exp_valid, exp_ask;
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ready_pct = ((c / 300) % 2) ? 85 : 15;
      if ($urandom_range(0, 199) == 0) src_sel = ~src_sel;
      wifi_iq_ready      = ($urandom_range(0, 99) < ready_pct);
      rf_iq_valid        = ($urandom_range(0, 99) < 70);
      cnt_clr            = ($urandom_range(0, 149) == 0);
      loopback_sel       = $urandom_range(0, 1) == 1;
      emptyn_from_s_axis = $urandom_range(0, 1) == 1;
      data_from_s_axis   = {$urandom(), $urandom()};
      randomize_rf();
      @(negedge clk);
      if (src_sel) begin
        exp_pack  = data_from_s_axis;
        exp_valid = emptyn_from_s_axis;
        exp_ask   = wifi_iq_ready;
      end else begin
        exp_pack  = (mq.size() == 0) ? '0 : mq[0];
        exp_valid = 1'b1;
        exp_ask   = 1'b0;
      end
      checks++;
      if ({wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis} !== {exp_pack, exp_valid, exp_ask}) begin
        errors++;
        $display("FAIL rand_out cycle %0d got=%h exp=%h", c,
                 {wifi_iq_pack, wifi_iq_valid, ask_data_from_s_axis}, {exp_pack, exp_valid, exp_ask});
      end
      checks++;
      if ({tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, underrun_cnt, overflow_cnt}
          !== {mq.size() == 0, mq.size() == DEPTH, (AW+1)'(mq.size()), 16'(m_und), 16'(m_ovf)}) begin
        errors++;
        $display("FAIL rand_status cycle %0d got=%h exp=%h", c,
                 {tx_iq_fifo_empty, tx_iq_fifo_full, fifo_level, underrun_cnt, overflow_cnt},
                 {mq.size() == 0, mq.size() == DEPTH, (AW+1)'(mq.size()), 16'(m_und), 16'(m_ovf)});
      end
      checks++;
      if ({data_loopback, data_loopback_valid}
          !== (loopback_sel ? {rf_iq, rf_iq_valid} : {data_from_s_axis, emptyn_from_s_axis})) begin
        errors++;
        $display("FAIL rand_loopback cycle %0d got=%h exp=%h", c, {data_loopback, data_loopback_valid},
                 (loopback_sel ? {rf_iq, rf_iq_valid} : {data_from_s_axis, emptyn_from_s_axis}));
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst                = 1'b1;
    rf_iq              = '0;
    rf_iq_valid        = 1'b0;
    bb_gain            = '0;
    src_sel            = 1'b0;
    loopback_sel       = 1'b0;
    cnt_clr            = 1'b0;
    data_from_s_axis   = '0;
    emptyn_from_s_axis = 1'b0;
    wifi_iq_ready      = 1'b0;
    model_reset();

    test_reset();
    test_gain_basic();
    test_gain_sat();
    test_overflow();
    test_underrun();
    test_flush_passthrough();
    test_reset_mid_burst();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
